// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// default register-address width.
package hazard_pkg;

    localparam int unsigned RegwDefault = 5;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMdWait  = 2'd1,
        StMemWait = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the IF/ID sources and a load sitting
// in ID/EX.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REGW = RegwDefault
) (
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic [REGW-1:0] ex_rd_i,
    input  logic            ex_memread_i,
    input  logic            ex_regwrite_i,
    output logic            load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use_o = ex_memread_i && ex_regwrite_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, multi-cycle
// mul/div freeze with timeout, and data-memory wait freeze.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REGW       = RegwDefault,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_memread,
    input  logic            ex_regwrite,
    input  logic            ex_br_taken,
    input  logic            ex_md_start,
    input  logic            md_done,
    input  logic            mem_wait,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            md_err,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int unsigned TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(MD_TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    hz_state_e       prev_q, prev_d;
    hz_state_e       eff_st;
    logic [TW-1:0]   timer_q, timer_d;
    logic            md_err_q, md_err_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic            load_use;
    logic            freeze;
    logic            run_eval;

    hazard_detect #(
        .REGW (REGW)
    ) u_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .ex_rd_i       (ex_rd),
        .ex_memread_i  (ex_memread),
        .ex_regwrite_i (ex_regwrite),
        .load_use_o    (load_use)
    );

    // Once mem_wait drops, behave as the remembered state within the same cycle.
    assign eff_st = (state_q == StMemWait) ? prev_q : state_q;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        timer_d    = timer_q;
        md_err_d   = md_err_q;
        freeze     = 1'b0;
        run_eval   = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (mem_wait) begin
            freeze  = 1'b1;
            state_d = StMemWait;
            prev_d  = eff_st;
        end else begin
            case (eff_st)
                StMdWait: begin
                    if (md_done) begin
                        run_eval = 1'b1;
                        state_d  = StRun;
                        timer_d  = '0;
                    end else if (timer_q == TimerLast) begin
                        freeze   = 1'b1;
                        md_err_d = 1'b1;
                        state_d  = StRun;
                        timer_d  = '0;
                    end else begin
                        freeze   = 1'b1;
                        timer_d  = timer_q + 1'b1;
                    end
                end
                default: begin
                    run_eval = 1'b1;
                    state_d  = ex_md_start ? StMdWait : StRun;
                    timer_d  = '0;
                end
            endcase
        end

        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (run_eval) begin
            if (ex_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    assign stall_d = (!pc_en && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            prev_q   <= StRun;
            timer_q  <= '0;
            md_err_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            timer_q  <= timer_d;
            md_err_q <= md_err_d;
            stall_q  <= stall_d;
        end
    end

    assign md_err    = md_err_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REGW, default 5: register-address width.
REQ-002 SHALL have parameter MD_TIMEOUT, default 64: max cycles waiting for md_done before error.
REQ-003 SHALL have parameter CNTW, default 16: stall-counter width.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports id_rs1 and id_rs2, input, REGW each: IF/ID source registers.
REQ-007 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: the IF/ID instruction reads that source.
REQ-008 SHALL have port ex_rd, input, REGW: ID/EX destination register.
REQ-009 SHALL have ports ex_memread and ex_regwrite, input, 1 each: ID/EX is a load / writes ex_rd.
REQ-010 SHALL have port ex_br_taken, input, 1: taken branch or jump resolved in EX.
REQ-011 SHALL have port ex_md_start, input, 1: multi-cycle mul/div issued in EX this cycle.
REQ-012 SHALL have port md_done, input, 1: mul/div result valid (single-cycle pulse).
REQ-013 SHALL have port mem_wait, input, 1: data memory not ready.
REQ-014 SHALL have ports pc_en, ifid_en, idex_en and exmem_en, output, 1 each: stage register enables.
REQ-015 SHALL have ports ifid_flush and idex_flush, output, 1 each: insert bubble into that register.
REQ-016 SHALL have port md_err, output, 1: sticky mul/div timeout flag.
REQ-017 SHALL have port stall_cnt, output, CNTW: saturating count of stalled cycles.

Function
REQ-018 SHALL implement FSM states RUN, MD_WAIT, MEM_WAIT; state is registered, enables/flushes are combinational from state and inputs.
REQ-019 SHALL set, in RUN with no hazard: all enables=1, flushes=0.
REQ-020 SHALL detect load-use when ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-021 SHALL, on load-use in RUN: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; exactly one bubble per hazard, FSM stays in RUN.
REQ-022 SHALL, on ex_br_taken in RUN: ifid_flush=1, idex_flush=1, all enables=1; branch overrides load-use in the same cycle.
REQ-023 SHALL, on ex_md_start in RUN: go to MD_WAIT; while in MD_WAIT, pc_en=ifid_en=idex_en=0 and exmem_en=0.
REQ-024 SHALL, in MD_WAIT on md_done: return to RUN with RUN outputs in the same cycle; md_done arriving in RUN is ignored.
REQ-025 SHALL count MD_WAIT cycles; on reaching MD_TIMEOUT, set md_err and return to RUN; md_err stays set until reset.
REQ-026 SHALL, on mem_wait from any state: all enables=0, flushes=0; enter MEM_WAIT, remembering the previous state; on mem_wait low, return to the remembered state.
REQ-027 SHALL apply priority mem_wait > MD_WAIT > ex_br_taken > load-use.
REQ-028 SHALL, if ex_md_start and ex_br_taken occur together: flush and enter MD_WAIT.
REQ-029 SHALL increment stall_cnt every cycle pc_en=0, saturating at all-ones with no wrap.

Reset
REQ-030 SHALL, while rst_n=0: state=RUN, md timer=0, md_err=0, stall_cnt=0, all enables=0, ifid_flush=idex_flush=1.
REQ-031 SHALL, when reset asserts mid-MD_WAIT or mid-MEM_WAIT, abort immediately with no residual state after release.

Structure
REQ-032 SHALL place the state enum and the REGW default in a shared package hazard_pkg.
REQ-033 SHALL instantiate one sub-module, hazard_detect: combinational load-use compare (REQ-020).

Verification
REQ-034 SHALL cover: lw x5 then add x6,x5,x1 (ex_rd=5, id_rs1=5) -> one cycle pc_en=0, idex_flush=1, then RUN; stall_cnt=1.
REQ-035 SHALL cover: same as REQ-034 with ex_rd=0 -> no stall.
REQ-036 SHALL cover: ex_br_taken plus load-use in the same cycle -> both flushes=1, pc_en=1.
REQ-037 SHALL cover: ex_md_start, md_done 5 cycles later -> 5 frozen cycles, then RUN; stall_cnt=5.
REQ-038 SHALL cover: ex_md_start with no md_done -> md_err=1 after 64 cycles, back to RUN.
REQ-039 SHALL cover: mem_wait for 3 cycles during MD_WAIT, then md_done -> return to MD_WAIT after mem_wait, then RUN; a reset pulse mid-wait clears everything.
